// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds the width codes, the FSM state encoding and the width/alignment legality check.
package mem_access_unit_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } mem_state_e;

    // True when the width code exists and the address is naturally aligned for it.
    function automatic logic op_aligned_legal(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo);
        logic ok;
        case (funct3)
            LS_B, LS_BU: ok = 1'b1;
            LS_H, LS_HU: ok = ~addr_lo[0];
            LS_W:        ok = (addr_lo == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// The load/store unit is the master; the memory is the slave.
interface mem_access_unit_if;

    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_we;
    logic [31:0] dmem_req_addr;
    logic [3:0]  dmem_req_be;
    logic [31:0] dmem_req_wdata;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_rdata;

    modport master (
        output dmem_req_valid,
        output dmem_req_we,
        output dmem_req_addr,
        output dmem_req_be,
        output dmem_req_wdata,
        input  dmem_req_ready,
        input  dmem_resp_valid,
        input  dmem_resp_rdata
    );

    modport slave (
        input  dmem_req_valid,
        input  dmem_req_we,
        input  dmem_req_addr,
        input  dmem_req_be,
        input  dmem_req_wdata,
        output dmem_req_ready,
        output dmem_resp_valid,
        output dmem_resp_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// Combinational lane logic: extracts and extends load data from the raw read word,
// and builds byte enables plus lane-replicated write data for stores.
module mem_access_unit_load_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data,
    input  logic [1:0]  st_width,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        case (ld_funct3)
            LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LS_BU:   ld_data = {24'h000000, ld_byte};
            LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LS_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

    always_comb begin
        case (st_width)
            2'b00: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{st_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one valid/ready bus transaction per load/store,
// then aligned load data toward MEM/WB; mem_busy locks the pipeline meanwhile.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_read,
    input  logic              op_write,
    input  logic [2:0]        op_funct3,
    input  logic [31:0]       op_addr,
    input  logic [31:0]       op_wdata,
    mem_access_unit_if.master dmem,
    output logic [31:0]       mem_read_data,
    output logic              mem_busy,
    output logic              mem_err
);

    mem_state_e  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  lo_q, lo_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        op_any, op_ok, start, reject, timed_out;
    logic [31:0] load_data, st_wdata;
    logic [3:0]  st_be;

    assign op_any    = op_read | op_write;
    assign op_ok     = op_aligned_legal(op_funct3, op_addr[1:0]) & ~(op_read & op_write);
    assign start     = (state_q == StIdle) & op_any & ~flush & op_ok;
    assign reject    = (state_q == StIdle) & op_any & ~flush & ~op_ok;
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TIMEOUT - 1);

    // Load side uses the width/offset captured at start; store side the live op.
    mem_access_unit_load_align u_align (
        .ld_funct3  (funct3_q),
        .ld_addr_lo (lo_q),
        .ld_rdata   (dmem.dmem_resp_rdata),
        .ld_data    (load_data),
        .st_width   (op_funct3[1:0]),
        .st_addr_lo (op_addr[1:0]),
        .st_data    (op_wdata),
        .st_be      (st_be),
        .st_wdata   (st_wdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        wdata_d  = wdata_q;
        funct3_d = funct3_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        err_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StReq;
                    we_d     = op_write;
                    addr_d   = {op_addr[31:2], 2'b00};
                    be_d     = st_be;
                    wdata_d  = st_wdata;
                    funct3_d = op_funct3;
                    lo_d     = op_addr[1:0];
                end
                err_d = reject;
            end
            StReq: begin
                if (dmem.dmem_req_ready) begin
                    state_d = StWait;
                    cnt_d   = 32'd0;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 32'd1;
                // A response in the final allowed cycle still wins over the timeout.
                if (dmem.dmem_resp_valid) begin
                    state_d = StDone;
                    if (!we_q) rdata_d = load_data;
                end else if (timed_out) begin
                    state_d = StDone;
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= 32'd0;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            funct3_q <= 3'd0;
            lo_q     <= 2'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            funct3_q <= funct3_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign dmem.dmem_req_valid = (state_q == StReq);
    assign dmem.dmem_req_we    = we_q;
    assign dmem.dmem_req_addr  = addr_q;
    assign dmem.dmem_req_be    = be_q;
    assign dmem.dmem_req_wdata = wdata_q;

    assign mem_read_data = rdata_q;
    assign mem_err       = err_q;
    assign mem_busy      = start | (state_q == StReq) | (state_q == StWait);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, hand-written corner sequences and
// randomized loads/stores against a byte-addressed memory model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        op_read = 1'b0;
    logic        op_write = 1'b0;
    logic [2:0]  op_funct3 = 3'd0;
    logic [31:0] op_addr = 32'd0;
    logic [31:0] op_wdata = 32'd0;
    logic [31:0] mem_read_data;
    logic        mem_busy;
    logic        mem_err;

    int          n_vec = 0;
    int          n_fail = 0;
    logic [31:0] prev_data;
    logic [7:0]  mem [0:255];

    mem_access_unit_if bus ();

    mem_access_unit #(.TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .op_read       (op_read),
        .op_write      (op_write),
        .op_funct3     (op_funct3),
        .op_addr       (op_addr),
        .op_wdata      (op_wdata),
        .dmem          (bus),
        .mem_read_data (mem_read_data),
        .mem_busy      (mem_busy),
        .mem_err       (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          exp_busy;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int width_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    function automatic bit is_legal(input logic rd, input logic wr, input logic [2:0] f3,
                                    input logic [31:0] addr);
        int w;
        w = width_of(f3);
        if (!(rd || wr) || (rd && wr) || w == 0) return 1'b0;
        return (int'(addr[1:0]) % w) == 0;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        int b;
        b = int'(addr[7:2]) * 4;
        return {mem[b + 3], mem[b + 2], mem[b + 1], mem[b]};
    endfunction

    // Byte/half/word picked out by shifting, then widened by value.
    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] word);
        int              w;
        longint unsigned v, mask;
        w    = width_of(f3);
        mask = (64'd1 << (8 * w)) - 64'd1;
        v    = (longint'(word) >> (8 * int'(addr[1:0]))) & mask;
        if (f3 < 3'd4 && w < 4 && v >= (64'd1 << (8 * w - 1))) v = v | (64'hFFFF_FFFF & ~mask);
        return v[31:0];
    endfunction

    task automatic run_op(
        input  logic rd_i, input logic wr_i, input logic [2:0] f3_i,
        input  logic [31:0] addr_i, input logic [31:0] wdata_i,
        input  int rdy_dly, input int resp_k, input logic [31:0] rdata_i, input logic fl_i,
        output int busy_n, output int acc_n, output logic stable,
        output logic we_o, output logic [31:0] addr_o, output logic [3:0] be_o,
        output logic [31:0] wdata_o, output logic [31:0] data_o,
        output logic err_done, output logic err_next);
        int   valid_n, waitc;
        logic accepted, resolved, done, acc_now;
        busy_n = 0; acc_n = 0; stable = 1'b1; we_o = 1'b0; addr_o = '0; be_o = '0;
        wdata_o = '0; data_o = '0; err_done = 1'b0; err_next = 1'b0;
        valid_n = 0; waitc = 0; accepted = 1'b0; resolved = 1'b0; done = 1'b0;
        op_read = rd_i; op_write = wr_i; op_funct3 = f3_i; op_addr = addr_i; op_wdata = wdata_i;
        flush = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            bus.dmem_resp_valid = 1'b0;
            bus.dmem_resp_rdata = $urandom;
            if (bus.dmem_req_valid) begin
                if (valid_n == 0) begin
                    we_o = bus.dmem_req_we; addr_o = bus.dmem_req_addr;
                    be_o = bus.dmem_req_be; wdata_o = bus.dmem_req_wdata;
                end else if ({we_o, addr_o, be_o, wdata_o} != {bus.dmem_req_we,
                             bus.dmem_req_addr, bus.dmem_req_be, bus.dmem_req_wdata}) begin
                    stable = 1'b0;
                end
                valid_n++;
                bus.dmem_req_ready = (valid_n > rdy_dly);
                flush = fl_i;
            end else begin
                bus.dmem_req_ready = 1'($urandom_range(0, 1));
                if (accepted && !resolved) begin
                    waitc++;
                    flush = fl_i;
                    if (waitc == resp_k) begin
                        bus.dmem_resp_valid = 1'b1;
                        bus.dmem_resp_rdata = rdata_i;
                        resolved = 1'b1;
                    end else if (waitc == TMO) begin
                        resolved = 1'b1;
                    end
                end else begin
                    bus.dmem_resp_valid = 1'($urandom_range(0, 1));
                end
            end
            @(negedge clk);
            acc_now = bus.dmem_req_valid & bus.dmem_req_ready;
            if (acc_now) acc_n++;
            if (mem_busy) busy_n++;
            else begin
                done = 1'b1; data_o = mem_read_data; err_done = mem_err;
            end
            @(posedge clk); #1;
            if (acc_now) accepted = 1'b1;
        end
        if (!done) busy_n = -1;
        op_read = 1'b0; op_write = 1'b0; flush = 1'b0;
        bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0;
        @(negedge clk);
        err_next = mem_err;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 32'(bus.dmem_req_valid), 32'd0);
        check({tag, "_we"},        32'(bus.dmem_req_we), 32'd0);
        check({tag, "_addr"},      bus.dmem_req_addr, 32'd0);
        check({tag, "_be"},        32'(bus.dmem_req_be), 32'd0);
        check({tag, "_wdata"},     bus.dmem_req_wdata, 32'd0);
        check({tag, "_data"},      mem_read_data, 32'd0);
        check({tag, "_busy"},      32'(mem_busy), 32'd0);
        check({tag, "_err"},       32'(mem_err), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [14];
        int          busy_n, acc_n;
        logic        stable, we_o, err_done, err_next;
        logic [31:0] addr_o, wdata_o, data_o;
        logic [3:0]  be_o;
        logic [2:0]  legal_f3 [5];
        logic        r, w, fl;
        logic [2:0]  f3;
        logic [31:0] a, wd, exp_wd, word;
        logic [3:0]  exp_be;
        int          rdy, k, wdt, exp_busy;

        bus.dmem_req_ready = 1'b0;
        bus.dmem_resp_valid = 1'b0;
        bus.dmem_resp_rdata = 32'd0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        prev_data = 32'd0;

        tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 4, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 4, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 4, 4'h0, 32'h0, 32'h00000080, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF0000, 4, 4'h0, 32'h0, 32'h000080FF, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 4, 4'h0, 32'h0, 32'hFFFF80FF, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 3'b000, 32'h201, 32'hAB, 32'h0, 4, 4'b0010, 32'hABABABAB, 32'hFFFF80FF, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 3'b001, 32'h202, 32'h1234, 32'h0, 4, 4'b1100, 32'h12341234, 32'hFFFF80FF, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 3'b010, 32'h204, 32'hCAFEF00D, 32'h0, 4, 4'b1111, 32'hCAFEF00D, 32'hFFFF80FF, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'hFFFF80FF, 1'b1};
        tbl[9]  = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'hFFFF80FF, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 3'b010, 32'h100, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'hFFFF80FF, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'hFFFF80FF, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'b001, 32'h106, 32'h0, 32'h7FFF1234, 4, 4'h0, 32'h0, 32'h00007FFF, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0, 32'h0000007F, 4, 4'h0, 32'h0, 32'h0000007F, 1'b0};

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, 0, 2, tbl[i].rdata,
                   1'b0, busy_n, acc_n, stable, we_o, addr_o, be_o, wdata_o, data_o, err_done,
                   err_next);
            check($sformatf("tbl%0d_busy", i), 32'(busy_n), 32'(tbl[i].exp_busy));
            check($sformatf("tbl%0d_reqs", i), 32'(acc_n), (tbl[i].exp_busy > 0) ? 32'd1 : 32'd0);
            check($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
            check($sformatf("tbl%0d_err", i), 32'(err_next), 32'(tbl[i].exp_err));
            if (tbl[i].wr && tbl[i].exp_busy > 0) begin
                check($sformatf("tbl%0d_be", i), 32'(be_o), 32'(tbl[i].exp_be));
                check($sformatf("tbl%0d_wdata", i), wdata_o, tbl[i].exp_wdata);
            end
        end

        // Ready held low for 5 cycles, flush raised through REQ and WAIT.
        run_op(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 5, 2, 32'h01234567, 1'b1, busy_n, acc_n,
               stable, we_o, addr_o, be_o, wdata_o, data_o, err_done, err_next);
        check("stall_busy", 32'(busy_n), 32'd9);
        check("stall_stable", 32'(stable), 32'd1);
        check("stall_addr", addr_o, 32'h104);
        check("stall_data", data_o, 32'h01234567);

        // No response: abandon after TMO WAIT cycles.
        run_op(1'b1, 1'b0, 3'b010, 32'h108, 32'h0, 0, 100, 32'h0, 1'b0, busy_n, acc_n,
               stable, we_o, addr_o, be_o, wdata_o, data_o, err_done, err_next);
        check("tmo_busy", 32'(busy_n), 32'(2 + TMO));
        check("tmo_data", data_o, 32'd0);
        check("tmo_err_done", 32'(err_done), 32'd1);
        check("tmo_err_after", 32'(err_next), 32'd0);

        run_op(1'b1, 1'b0, 3'b010, 32'h10C, 32'h0, 1, 4, 32'h5A5A5A5A, 1'b0, busy_n, acc_n,
               stable, we_o, addr_o, be_o, wdata_o, data_o, err_done, err_next);
        check("lw4_busy", 32'(busy_n), 32'd7);
        check("lw4_data", data_o, 32'h5A5A5A5A);

        // Reset while waiting for a response.
        op_read = 1'b1; op_funct3 = 3'b010; op_addr = 32'h300; bus.dmem_req_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_pre_busy", 32'(mem_busy), 32'd1);
        #2;
        rst = 1'b1; op_read = 1'b0; bus.dmem_req_ready = 1'b0;
        @(negedge clk);
        check_all_zero("rst_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        prev_data = 32'd0;

        // Flush in IDLE kills the op outright.
        op_read = 1'b1; op_funct3 = 3'b010; op_addr = 32'h100; flush = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("flush_idle_busy", 32'(mem_busy), 32'd0);
            @(posedge clk); #1;
            check("flush_idle_req", 32'(bus.dmem_req_valid), 32'd0);
        end
        op_read = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_err", 32'(mem_err), 32'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0:             begin r = 1'b1; w = 1'b1; end
                1, 2, 3, 4:    begin r = 1'b0; w = 1'b1; end
                default:       begin r = 1'b1; w = 1'b0; end
            endcase
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
            else f3 = legal_f3[$urandom_range(0, 4)];
            a = 32'h0000_1000 | 32'($urandom_range(0, 255));
            wdt = width_of(f3);
            if ($urandom_range(0, 4) != 0) begin
                if (wdt == 2) a[0] = 1'b0;
                if (wdt == 4) a[1:0] = 2'b00;
            end
            wd = $urandom; rdy = $urandom_range(0, 3); k = $urandom_range(1, 6);
            fl = 1'($urandom_range(0, 1));
            word = mem_word(a);
            run_op(r, w, f3, a, wd, rdy, k, word, fl, busy_n, acc_n, stable, we_o, addr_o,
                   be_o, wdata_o, data_o, err_done, err_next);
            if (is_legal(r, w, f3, a)) begin
                exp_busy = 2 + rdy + ((k < TMO) ? k : TMO);
                check($sformatf("rnd%0d_busy", n), 32'(busy_n), 32'(exp_busy));
                check($sformatf("rnd%0d_reqs", n), 32'(acc_n), 32'd1);
                check($sformatf("rnd%0d_addr", n), addr_o, a & 32'hFFFF_FFFC);
                check($sformatf("rnd%0d_we", n), 32'(we_o), 32'(w));
                check($sformatf("rnd%0d_stable", n), 32'(stable), 32'd1);
                if (w) begin
                    exp_be = 4'(((1 << wdt) - 1) << int'(a[1:0]));
                    exp_wd = (wdt == 1) ? 32'(wd[7:0]) * 32'h01010101 :
                             (wdt == 2) ? 32'(wd[15:0]) * 32'h00010001 : wd;
                    check($sformatf("rnd%0d_be", n), 32'(be_o), 32'(exp_be));
                    check($sformatf("rnd%0d_wdata", n), wdata_o, exp_wd);
                    for (int j = 0; j < wdt; j++) mem[(int'(a[7:0]) + j) % 256] = 8'(wd >> (8 * j));
                end
                if (k > TMO) prev_data = 32'd0;
                else if (r) prev_data = load_value(f3, a, word);
                check($sformatf("rnd%0d_data", n), data_o, prev_data);
                check($sformatf("rnd%0d_err_done", n), 32'(err_done), (k > TMO) ? 32'd1 : 32'd0);
                check($sformatf("rnd%0d_err_after", n), 32'(err_next), 32'd0);
            end else begin
                check($sformatf("rnd%0d_busy", n), 32'(busy_n), 32'd0);
                check($sformatf("rnd%0d_reqs", n), 32'(acc_n), 32'd0);
                check($sformatf("rnd%0d_data", n), data_o, prev_data);
                check($sformatf("rnd%0d_err", n), 32'(err_next), 32'd1);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
